// File: rtl/block_data_memory_pkg.sv
// Shared definitions for the block data memory: FSM encodings, default widths and latency.
package block_data_memory_pkg;

  localparam int DMEM_ADDR_W  = 6;
  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_LATENCY = 5;
  localparam int DMEM_CNT_W   = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_t;

  // The counter is preloaded with LATENCY-1 so that BUSY lasts exactly LATENCY cycles.
  function automatic logic [DMEM_CNT_W-1:0] latency_preload(input int latency);
    return DMEM_CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// Loadable 4-bit down-counter that paces the BUSY phase of a memory access.
module dmem_latency_counter
  import block_data_memory_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  dec,
  input  logic [DMEM_CNT_W-1:0] load_value,
  output logic                  zero
);

  logic [DMEM_CNT_W-1:0] count;

  assign zero = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - DMEM_CNT_W'(1);
    end
  end

endmodule

// File: rtl/block_data_memory.sv
// Block-organised data memory behind the data cache, fixed programmable access latency.
// Define DMEM_CLEAR_ON_RESET_EN to zero the whole array whenever reset is asserted.
module block_data_memory
  import block_data_memory_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_writedata,
  output logic [DATA_W-1:0] mem_readdata,
  output logic              mem_busywait
);

  localparam int                    DEPTH       = 2 ** ADDR_W;
  localparam logic [DMEM_CNT_W-1:0] CNT_PRELOAD = latency_preload(LATENCY);

  dmem_state_t       state, state_next;
  logic              req;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              do_access, wr_en;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_write;
  logic [DATA_W-1:0] mem [DEPTH];

  assign req   = mem_read | mem_write;
  assign wr_en = do_access & lat_write;

  dmem_latency_counter u_latency_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (CNT_PRELOAD),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= DMEM_IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      DMEM_IDLE: if (req)      state_next = DMEM_BUSY;
      DMEM_BUSY: if (cnt_zero) state_next = DMEM_DONE;
      DMEM_DONE:               state_next = DMEM_IDLE;
      default:                 state_next = DMEM_IDLE;
    endcase
  end

  always_comb begin
    mem_busywait = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    do_access    = 1'b0;
    unique case (state)
      DMEM_IDLE: begin
        mem_busywait = req;
        cnt_load     = req;
      end
      DMEM_BUSY: begin
        mem_busywait = 1'b1;
        cnt_dec      = 1'b1;
        do_access    = cnt_zero;
      end
      default: ;
    endcase
  end

  // Request is captured once; the cache may change its inputs while BUSY without effect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
    end else if (cnt_load) begin
      lat_addr  <= mem_address;
      lat_data  <= mem_writedata;
      lat_write <= mem_write;
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[lat_addr] <= lat_data;
    end
  end
`else
  // NOTE: the array has no reset so it maps onto plain RAM; contents survive a control reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[lat_addr] <= lat_data;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_readdata <= '0;
    end else if (do_access && !lat_write) begin
      mem_readdata <= mem[lat_addr];
    end
  end

endmodule
